// File: rtl/rv_pkg.sv
// Shared encodings for the RV32I multi-cycle datapath: immediate formats,
// ALU operations and ALU B-operand selects.
package rv_pkg;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SRA = 3'b111;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;
  localparam logic [1:0] SRCB_ZERO = 2'b11;

endpackage

// File: rtl/alu.sv
// Combinational ALU. Add/sub wrap; shifts use only the low five bits of b.
module alu
  import rv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_control,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  logic lt;

  assign lt = $signed(a) < $signed(b);

  always_comb begin
    result = '0;
    case (alu_control)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, lt};
      ALU_SRL: result = a >> b[4:0];
      ALU_SRA: result = $signed(a) >>> b[4:0];
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/extend.sv
// Immediate sign-extender. The instr port carries instruction bits [31:7],
// so instruction bit i appears at instr[i-7].
module extend
  import rv_pkg::*;
(
  input  logic [24:0] instr,
  input  logic [2:0]  imm_src,
  output logic [31:0] imm_ext
);

  always_comb begin
    imm_ext = 32'h0;
    case (imm_src)
      IMM_I: imm_ext = {{20{instr[24]}}, instr[24:13]};
      IMM_S: imm_ext = {{20{instr[24]}}, instr[24:18], instr[4:0]};
      IMM_B: imm_ext = {{19{instr[24]}}, instr[24], instr[0], instr[23:18], instr[4:1], 1'b0};
      IMM_J: imm_ext = {{11{instr[24]}}, instr[24], instr[12:5], instr[13], instr[23:14], 1'b0};
      IMM_U: imm_ext = {instr[24:5], 12'b0};
      default: imm_ext = 32'h0;
    endcase
  end

endmodule

// File: rtl/flopenr.sv
// Enabled register with asynchronous active-low clear.
module flopenr #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/exec_unit.sv
// Execute-stage slice: immediate extender, ALU with B-operand select and the
// enabled ALUOut register feeding the next cycle.
module exec_unit
  import rv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [24:0]      instr,
  input  logic [2:0]       imm_src,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] reg_b,
  input  logic [1:0]       alu_src_b,
  input  logic [2:0]       alu_control,
  input  logic             alu_out_en,
  output logic [31:0]      imm_ext,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic [WIDTH-1:0] alu_out
);

  logic [WIDTH-1:0] src_b;

  extend u_extend (
    .instr   (instr),
    .imm_src (imm_src),
    .imm_ext (imm_ext)
  );

  always_comb begin
    src_b = '0;
    case (alu_src_b)
      SRCB_REG:  src_b = reg_b;
      SRCB_IMM:  src_b = WIDTH'(imm_ext);
      SRCB_FOUR: src_b = WIDTH'(4);
      SRCB_ZERO: src_b = '0;
      default:   src_b = '0;
    endcase
  end

  alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a           (src_a),
    .b           (src_b),
    .alu_control (alu_control),
    .result      (alu_result),
    .zero        (zero)
  );

  flopenr #(
    .WIDTH (WIDTH)
  ) u_alu_out_reg (
    .clk    (clk),
    .resetn (resetn),
    .en     (alu_out_en),
    .d      (alu_result),
    .q      (alu_out)
  );

endmodule

// File: tb/tb_exec_unit.sv
// Scoreboard bench for exec_unit: directed vectors plus random traffic checked
// against an arithmetic reference model.
module tb_exec_unit;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic [24:0] instr;
  logic [2:0]  imm_src;
  logic [31:0] src_a;
  logic [31:0] reg_b;
  logic [1:0]  alu_src_b;
  logic [2:0]  alu_control;
  logic        alu_out_en;
  logic [31:0] imm_ext;
  logic [31:0] alu_result;
  logic        zero;
  logic [31:0] alu_out;

  typedef struct {
    logic [31:0] imm;
    logic [31:0] res;
    logic        z;
    logic [31:0] out;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          vec_id = 0;
  logic [31:0] model_out = 32'h0;

  always #5 clk = ~clk;

  exec_unit #(
    .WIDTH (32)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .instr       (instr),
    .imm_src     (imm_src),
    .src_a       (src_a),
    .reg_b       (reg_b),
    .alu_src_b   (alu_src_b),
    .alu_control (alu_control),
    .alu_out_en  (alu_out_en),
    .imm_ext     (imm_ext),
    .alu_result  (alu_result),
    .zero        (zero),
    .alu_out     (alu_out)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Reference model works on the full 32-bit instruction word.
  function automatic logic [31:0] ref_imm(input logic [31:0] ins, input logic [2:0] sel);
    logic [11:0] i12;
    logic [12:0] b13;
    logic [20:0] j21;
    case (sel)
      IMM_I: begin i12 = ins[31:20]; return 32'($signed(i12)); end
      IMM_S: begin i12 = {ins[31:25], ins[11:7]}; return 32'($signed(i12)); end
      IMM_B: begin
        b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        return 32'($signed(b13));
      end
      IMM_J: begin
        j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        return 32'($signed(j21));
      end
      IMM_U: return ins & 32'hFFFF_F000;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    int sa;
    int sb;
    int sh;
    sa = int'(a);
    sb = int'(b);
    sh = int'(b % 32);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      ALU_SLT: return (sa < sb) ? 32'd1 : 32'd0;
      ALU_SRL: return a >> sh;
      default: return 32'(sa >>> sh);
    endcase
  endfunction

  task automatic send(input logic [31:0] ins, input logic [2:0] isel, input logic [31:0] a,
                      input logic [31:0] b, input logic [1:0] bsel, input logic [2:0] op,
                      input logic en);
    exp_t        e;
    logic [31:0] opb;
    @(negedge clk);
    instr       = ins[31:7];
    imm_src     = isel;
    src_a       = a;
    reg_b       = b;
    alu_src_b   = bsel;
    alu_control = op;
    alu_out_en  = en;
    e.imm = ref_imm(ins, isel);
    case (bsel)
      2'd0:    opb = b;
      2'd1:    opb = e.imm;
      2'd2:    opb = 32'd4;
      default: opb = 32'd0;
    endcase
    e.res = ref_alu(a, opb, op);
    e.z   = (e.res == 32'd0);
    if (en) model_out = e.res;
    e.out = model_out;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
  endtask

  // Monitor: combinational outputs are stable from the driving negedge, and
  // alu_out reflects the edge just taken.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check($sformatf("v%0d imm_ext", vec_id), imm_ext, e.imm);
        check($sformatf("v%0d alu_result", vec_id), alu_result, e.res);
        check($sformatf("v%0d zero", vec_id), {31'b0, zero}, {31'b0, e.z});
        check($sformatf("v%0d alu_out", vec_id), alu_out, e.out);
        vec_id++;
      end
    end
  end

  initial begin
    resetn      = 1'b0;
    instr       = '0;
    imm_src     = '0;
    src_a       = '0;
    reg_b       = '0;
    alu_src_b   = '0;
    alu_control = '0;
    alu_out_en  = 1'b1;
    repeat (2) @(negedge clk);
    check("reset alu_out", alu_out, 32'h0);
    resetn = 1'b1;

    // Extender
    send(32'hFFF00093, IMM_I, 32'h0, 32'h0, SRCB_IMM, ALU_ADD, 1'b0);
    send(32'h00134313, IMM_I, 32'h0, 32'h0, SRCB_IMM, ALU_ADD, 1'b0);
    send(32'h00112623, IMM_S, 32'h0, 32'h0, SRCB_IMM, ALU_ADD, 1'b0);
    send(32'hFE000EE3, IMM_B, 32'h0, 32'h0, SRCB_IMM, ALU_ADD, 1'b0);
    send(32'h0080006F, IMM_J, 32'h0, 32'h0, SRCB_IMM, ALU_ADD, 1'b0);
    send(32'h009893B7, IMM_U, 32'h0, 32'h0, SRCB_IMM, ALU_ADD, 1'b0);
    send(32'hFFFFFFFF, 3'b111, 32'h0, 32'h0, SRCB_IMM, ALU_ADD, 1'b0);
    // ALU
    send(32'h0, IMM_I, 32'd5, 32'd3, SRCB_REG, ALU_ADD, 1'b1);
    send(32'h0, IMM_I, 32'd3, 32'd5, SRCB_REG, ALU_SUB, 1'b1);
    send(32'h0, IMM_I, 32'd7, 32'd7, SRCB_REG, ALU_SUB, 1'b1);
    send(32'h0, IMM_I, 32'hFFFFFFFF, 32'd1, SRCB_REG, ALU_ADD, 1'b1);
    send(32'h0, IMM_I, 32'hF0F0, 32'hFF00, SRCB_REG, ALU_AND, 1'b1);
    send(32'h0, IMM_I, 32'hF0F0, 32'hFF00, SRCB_REG, ALU_OR, 1'b1);
    send(32'h0, IMM_I, 32'hF0F0, 32'hFF00, SRCB_REG, ALU_XOR, 1'b1);
    send(32'h0, IMM_I, 32'hFFFFFFFF, 32'd1, SRCB_REG, ALU_SLT, 1'b1);
    send(32'h0, IMM_I, 32'd1, 32'hFFFFFFFF, SRCB_REG, ALU_SLT, 1'b1);
    send(32'h0, IMM_I, 32'h80000000, 32'd4, SRCB_REG, ALU_SRL, 1'b1);
    send(32'h0, IMM_I, 32'h80000000, 32'd4, SRCB_REG, ALU_SRA, 1'b1);
    // B mux
    send(32'h0, IMM_I, 32'h100, 32'h55, SRCB_FOUR, ALU_ADD, 1'b1);
    send(32'hFFF00093, IMM_I, 32'h10, 32'h55, SRCB_IMM, ALU_ADD, 1'b1);
    send(32'h0, IMM_I, 32'hCAFE, 32'h55, SRCB_ZERO, ALU_ADD, 1'b1);
    // Register enable/hold
    send(32'h0, IMM_I, 32'h1000, 32'h234, SRCB_REG, ALU_ADD, 1'b1);
    send(32'h0, IMM_I, 32'h5000, 32'h678, SRCB_REG, ALU_ADD, 1'b0);
    drain();

    // Reset pulse between edges clears alu_out even with enable high.
    @(negedge clk);
    alu_out_en = 1'b1;
    #1 resetn = 1'b0;
    #1 check("reset pulse clear", alu_out, 32'h0);
    alu_out_en = 1'b0;
    #1 resetn = 1'b1;
    model_out = 32'h0;
    @(posedge clk);
    #1 check("hold after reset pulse", alu_out, 32'h0);

    for (int i = 0; i < 200; i++) begin
      send($urandom, 3'($urandom_range(0, 7)),
           ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom,
           ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom,
           2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
Execute-stage slice of the multi-cycle RV32I datapath. It combines the immediate sign-extender, the 32-bit ALU with its B-operand select, and an enabled result register (ALUOut). It sits between the register-file/operand-A mux and the result mux. The combinational result and zero flag feed branch logic; the registered result feeds the next cycle.

Parameters:
WIDTH, 32, datapath width of the ALU operands and the result register (the extender is fixed at 32).

Ports:
clk  in  1  rising-edge clock
resetn  in  1  asynchronous, active-low reset
instr  in  25  instruction bits [31:7]; instr[i-7] carries instruction bit i
imm_src  in  3  immediate format select
src_a  in  WIDTH  ALU operand A, already muxed upstream
reg_b  in  WIDTH  register operand (rs2 value)
alu_src_b  in  2  B select: 00 reg_b, 01 imm_ext, 10 constant 4, 11 zero
alu_control  in  3  ALU operation
alu_out_en  in  1  result-register load enable
imm_ext  out  32  extended immediate (combinational)
alu_result  out  WIDTH  ALU result (combinational)
zero  out  1  high when alu_result == 0 (combinational)
alu_out  out  WIDTH  registered ALU result

Behaviour:
- Extender, combinational (bit numbers are instruction bits):
  - 000 I-type: {20{b31}, b31:20}.
  - 001 S-type: {20{b31}, b31:25, b11:7}.
  - 010 B-type: {19{b31}, b31, b7, b30:25, b11:8, 0}.
  - 011 J-type: {11{b31}, b31, b19:12, b20, b30:21, 0}.
  - 100 U-type: {b31:12, 12'b0}.
  - 101-111: output 32'h0.
- B-operand mux: per alu_src_b; code 11 gives zero.
- ALU, combinational:
  - 000 add, 001 sub, 010 and, 011 or, 100 xor.
  - 101 slt: signed compare; result is 1 or 0, zero-extended.
  - 110 srl, 111 sra; both shift by b[4:0].
- Add/sub wrap modulo 2^WIDTH; no carry or overflow outputs.
- zero = (alu_result == 0), for every operation.
- Result register (flopenr instance):
  - resetn low clears alu_out to 0 immediately, independent of clk.
  - On a rising clk edge with resetn high and alu_out_en high, alu_out <= alu_result.
  - With alu_out_en low, alu_out holds.
  - Latency: 1 cycle from alu_result to alu_out.
  - resetn deasserting at a clock edge: that edge does not load.
  - Reset asserted mid-operation clears alu_out even when alu_out_en is high.
- Reset values: alu_out = 0. All other outputs are combinational and follow their inputs during reset.
- No X propagation requirements beyond standard RTL semantics. Undefined select codes produce the defined values above, never X.

Decomposition:
- Shared package rv_pkg holds:
  - imm_src codes: IMM_I, IMM_S, IMM_B, IMM_J, IMM_U.
  - alu_control codes: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SRL, ALU_SRA.
  - alu_src_b codes.
- Sub-modules:
  - extend: combinational.
  - alu: combinational, parameterised by WIDTH.
  - flopenr #(WIDTH): async active-low reset, enable.
- exec_unit instantiates these three and the B mux.

Test Plan:
- Extender, I/S:
  - imm_src=000, instr=0xFFF00093[31:7] -> imm_ext=0xFFFFFFFF.
  - instr=0x00134313 -> 0x00000001.
  - imm_src=001, instr=0x00112623 -> 0x0000000C.
- Extender, B/J/U:
  - 010 with 0xFE000EE3 -> 0xFFFFFFFC.
  - 011 with 0x0080006F -> 0x00000008.
  - 100 with 0x009893B7 -> 0x00989000.
  - 111 -> 0x00000000.
- ALU arithmetic, src_a/reg_b, alu_src_b=00:
  - add 5+3 -> 8, zero=0.
  - sub 3-5 -> 0xFFFFFFFE.
  - sub 7-7 -> 0 with zero=1.
  - add 0xFFFFFFFF+1 -> 0 with zero=1.
- ALU logic/shift:
  - and 0xF0F0 & 0xFF00 -> 0xF000; or -> 0xFFF0; xor -> 0x0FF0.
  - slt -1 < 1 -> 1; slt 1 < -1 -> 0.
  - srl 0x80000000>>4 -> 0x08000000; sra -> 0xF8000000.
- B mux:
  - alu_src_b=10, src_a=0x100, add -> 0x104.
  - alu_src_b=01 with I-imm -1, src_a=0x10 -> 0x0F.
  - alu_src_b=11, add -> src_a.
- Register:
  - After reset alu_out=0.
  - en=1, result 0x1234 -> alu_out=0x1234 next edge.
  - en=0, result changes to 0x5678 -> alu_out stays 0x1234.
  - resetn pulsed low between edges -> alu_out=0 before the next edge.
